// File: rtl/spi_sensor_sequencer_if.sv
// Host, SPI-engine and result signals of spi_sensor_sequencer.
// master = the sequencer, slave = its surroundings. SEQ_TIMESTAMP_EN adds res_sweep.
interface spi_sensor_sequencer_if;
  logic        enable;
  logic        cfg_req;
  logic [15:0] cfg_cmd;
  logic        cfg_ack;
  logic        cfg_rvalid;
  logic [15:0] cfg_rdata;
  logic        spi_start;
  logic [15:0] spi_cmd;
  logic        spi_busy;
  logic        spi_done;
  logic [15:0] spi_rdata;
  logic        res_valid;
  logic [5:0]  res_ch;
  logic [15:0] res_data;
  logic        sweep_start;
  logic        overrun;
`ifdef SEQ_TIMESTAMP_EN
  logic [31:0] res_sweep;
`endif

  modport master (
    input  enable, cfg_req, cfg_cmd, spi_busy, spi_done, spi_rdata,
    output cfg_ack, cfg_rvalid, cfg_rdata, spi_start, spi_cmd,
           res_valid, res_ch, res_data, sweep_start, overrun
`ifdef SEQ_TIMESTAMP_EN
    , output res_sweep
`endif
  );

  modport slave (
    output enable, cfg_req, cfg_cmd, spi_busy, spi_done, spi_rdata,
    input  cfg_ack, cfg_rvalid, cfg_rdata, spi_start, spi_cmd,
           res_valid, res_ch, res_data, sweep_start, overrun
`ifdef SEQ_TIMESTAMP_EN
    , input res_sweep
`endif
  );
endinterface

// File: rtl/spi_sensor_sequencer.sv
// Periodic CONVERT sweeps plus host cfg frames over one SPI link; pipelined replies are
// re-aligned to their originating channel/request. SEQ_TIMESTAMP_EN adds res_sweep.
module spi_sensor_sequencer #(
  parameter int          N_CH          = 32,
  parameter int          SAMPLE_PERIOD = 200,
  parameter int          PIPE_DEPTH    = 2,
  parameter logic [15:0] DUMMY_CMD     = 16'hE800
) (
  input  logic clk,
  input  logic reset,
  spi_sensor_sequencer_if.master bus
);
  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam int FW = 7;
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;
  localparam logic [1:0] K_NONE = 2'd0, K_CONV = 2'd1, K_CFG = 2'd2, K_DUMMY = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [5:0] ch;
  } tag_t;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] frame_q, frame_d, burst_len;
  logic          sweep_q, sweep_d;
  logic [15:0]   cfg_cmd_q, cfg_cmd_d;
  tag_t [PIPE_DEPTH-1:0] pipe_q, pipe_d;
  tag_t          pop_q, pop_d, next_tag;
  logic [15:0]   next_word;
  logic          spi_start_q, spi_start_d;
  logic [15:0]   spi_cmd_q, spi_cmd_d;
  logic          cfg_ack_q, cfg_ack_d, cfg_rvalid_q, cfg_rvalid_d;
  logic [15:0]   cfg_rdata_q, cfg_rdata_d;
  logic          res_valid_q, res_valid_d;
  logic [5:0]    res_ch_q, res_ch_d;
  logic [15:0]   res_data_q, res_data_d;
  logic          sweep_start_q, sweep_start_d, overrun_q, overrun_d;
  logic          trigger;

  assign trigger   = bus.enable && (cnt_q == CW'(SAMPLE_PERIOD - 1));
  assign burst_len = sweep_q ? FW'(N_CH + PIPE_DEPTH) : FW'(1 + PIPE_DEPTH);

  // Frame word and tag for the frame about to be issued.
  always_comb begin
    next_word = DUMMY_CMD;
    next_tag  = '{kind: K_DUMMY, ch: 6'd0};
    if (sweep_q && frame_q < FW'(N_CH)) begin
      next_word = {2'b00, frame_q[5:0], 8'h00};
      next_tag  = '{kind: K_CONV, ch: frame_q[5:0]};
    end else if (!sweep_q && frame_q == '0) begin
      next_word = cfg_cmd_q;
      next_tag  = '{kind: K_CFG, ch: 6'd0};
    end
  end

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    sweep_d       = sweep_q;
    cfg_cmd_d     = cfg_cmd_q;
    pipe_d        = pipe_q;
    pop_d         = pop_q;
    spi_start_d   = 1'b0;
    spi_cmd_d     = spi_cmd_q;
    cfg_ack_d     = 1'b0;
    cfg_rvalid_d  = 1'b0;
    cfg_rdata_d   = cfg_rdata_q;
    res_valid_d   = 1'b0;
    res_ch_d      = res_ch_q;
    res_data_d    = res_data_q;
    sweep_start_d = 1'b0;
    overrun_d     = overrun_q || (trigger && state_q != S_IDLE);

    if (!bus.enable || cnt_q == CW'(SAMPLE_PERIOD - 1)) cnt_d = '0;
    else                                                cnt_d = cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          sweep_d = 1'b1;
          frame_d = '0;
          state_d = S_ISSUE;
        end else if (bus.cfg_req) begin
          sweep_d   = 1'b0;
          frame_d   = '0;
          cfg_cmd_d = bus.cfg_cmd;
          cfg_ack_d = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.spi_busy) begin
          spi_start_d   = 1'b1;
          spi_cmd_d     = next_word;
          sweep_start_d = sweep_q && frame_q == '0;
          // The tag falling off the end belongs to the frame whose reply arrives now.
          pop_d         = pipe_q[PIPE_DEPTH-1];
          pipe_d[0]     = next_tag;
          for (int i = 1; i < PIPE_DEPTH; i++) pipe_d[i] = pipe_q[i-1];
          frame_d       = frame_q + FW'(1);
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.spi_done) begin
          if (pop_q.kind == K_CONV) begin
            res_valid_d = 1'b1;
            res_ch_d    = pop_q.ch;
            res_data_d  = bus.spi_rdata;
          end else if (pop_q.kind == K_CFG) begin
            cfg_rvalid_d = 1'b1;
            cfg_rdata_d  = bus.spi_rdata;
          end
          state_d = (frame_q < burst_len) ? S_ISSUE : S_DONE;
        end
      end
      default: begin
        pipe_d  = '0;
        pop_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      frame_q       <= '0;
      sweep_q       <= 1'b0;
      cfg_cmd_q     <= '0;
      pipe_q        <= '0;
      pop_q         <= '0;
      spi_start_q   <= 1'b0;
      spi_cmd_q     <= '0;
      cfg_ack_q     <= 1'b0;
      cfg_rvalid_q  <= 1'b0;
      cfg_rdata_q   <= '0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_data_q    <= '0;
      sweep_start_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      sweep_q       <= sweep_d;
      cfg_cmd_q     <= cfg_cmd_d;
      pipe_q        <= pipe_d;
      pop_q         <= pop_d;
      spi_start_q   <= spi_start_d;
      spi_cmd_q     <= spi_cmd_d;
      cfg_ack_q     <= cfg_ack_d;
      cfg_rvalid_q  <= cfg_rvalid_d;
      cfg_rdata_q   <= cfg_rdata_d;
      res_valid_q   <= res_valid_d;
      res_ch_q      <= res_ch_d;
      res_data_q    <= res_data_d;
      sweep_start_q <= sweep_start_d;
      overrun_q     <= overrun_d;
    end
  end

`ifdef SEQ_TIMESTAMP_EN
  logic [31:0] sweep_cnt_q, sweep_cnt_d;
  assign sweep_cnt_d = sweep_cnt_q + (sweep_start_d ? 32'd1 : 32'd0);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sweep_cnt_q <= '0;
    else       sweep_cnt_q <= sweep_cnt_d;
  end
  assign bus.res_sweep = sweep_cnt_q;
`endif

  assign bus.spi_start   = spi_start_q;
  assign bus.spi_cmd     = spi_cmd_q;
  assign bus.cfg_ack     = cfg_ack_q;
  assign bus.cfg_rvalid  = cfg_rvalid_q;
  assign bus.cfg_rdata   = cfg_rdata_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_ch      = res_ch_q;
  assign bus.res_data    = res_data_q;
  assign bus.sweep_start = sweep_start_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: doc/spi_sensor_sequencer.md
# spi_sensor_sequencer

Schedules 16-bit command frames for the SPI sensor master: a periodic sweep of per-channel CONVERT commands plus host configuration accesses, sharing the one SPI link. Sits between the host/config logic and the SPI shift engine that drives MOSI_to_sensor/SCLK_wire/CS_b_wire. It re-aligns the sensor's pipelined replies, where frame N's result returns during frame N+PIPE_DEPTH, to their originating channel or host request.

## Interface
- N_CH, 32: channels per sweep, 1..64
- SAMPLE_PERIOD, 200: clk cycles between sweep triggers, ≥ 2
- PIPE_DEPTH, 2: frames between a command and its reply, 1..4
- DUMMY_CMD, 16'hE800: flush command word (READ reg 40)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  level; allows periodic sweeps
- cfg_req  in  1  host request, held until cfg_ack
- cfg_cmd  in  16  host command word, valid while cfg_req
- cfg_ack  out  1  one-cycle pulse: request accepted
- cfg_rvalid  out  1  one-cycle pulse: cfg_rdata valid
- cfg_rdata  out  16  sensor reply to the host command
- spi_start  out  1  one-cycle pulse: launch frame
- spi_cmd  out  16  frame word; stable from spi_start to spi_done
- spi_busy  in  1  SPI engine busy
- spi_done  in  1  one-cycle pulse: frame complete
- spi_rdata  in  16  word shifted in from MISO_from_sensor, valid with spi_done
- res_valid  out  1  one-cycle pulse per conversion result
- res_ch  out  6  channel of res_data
- res_data  out  16  conversion result
- sweep_start  out  1  one-cycle pulse at first frame of a sweep
- overrun  out  1  sticky; trigger arrived while a burst was active

## Operation
- Reset values: all outputs 0, spi_cmd 0, period counter 0, state IDLE.
- Period counter: counts 0..SAMPLE_PERIOD-1 while enable=1. Wraps with a one-cycle trigger. Held at 0 while enable=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: a pending trigger wins over cfg_req. A trigger starts a sweep burst of N_CH CONVERT frames for ch 0..N_CH-1, {2'b00, ch[5:0], 8'h00}, then PIPE_DEPTH DUMMY_CMD frames. Otherwise cfg_req starts a cfg burst, with cfg_ack pulsed that cycle and cfg_cmd latched: 1 cfg frame, then PIPE_DEPTH dummies.
- ISSUE: when spi_busy=0, pulse spi_start with the next word, push a tag {kind, ch} into a PIPE_DEPTH-deep shift register, then go to WAIT. kind is CONV, CFG or DUMMY.
- WAIT: on spi_done, pop the tag pushed PIPE_DEPTH frames earlier.
  - CONV: res_valid, res_ch=tag.ch, res_data=spi_rdata.
  - CFG: cfg_rvalid, cfg_rdata=spi_rdata.
  - DUMMY, or a slot empty since burst start: no output.
  - Then go to ISSUE if frames remain in the burst, else DONE.
- DONE: clear the tag pipeline, then go to IDLE.
- Trigger while not IDLE: dropped, and overrun set. Cleared only by reset.
- enable deasserted mid-sweep: the current burst completes; no new triggers.
- cfg_req during a sweep: waits, and is served at the next IDLE with no trigger pending.

## Timing
- spi_start comes 1 cycle after entering ISSUE with spi_busy=0. It is never asserted while spi_busy=1.
- res_valid/cfg_rvalid are registered: they fire 1 cycle after spi_done.
- The next spi_start is ≥ 1 cycle after spi_done.
- Sweep length is N_CH+PIPE_DEPTH frames.
- Latency from trigger to first spi_start is 2 cycles. sweep_start coincides with that spi_start.
- Asynchronous reset mid-frame forces spi_start=0 and drops every pending tag and result. No res_valid follows.

## Configuration
- SEQ_TIMESTAMP_EN defined: adds output res_sweep [31:0], the sweep index of the current result. It is 0 after reset, increments at each sweep_start, wraps at 2^32, and is valid with res_valid.
- SEQ_TIMESTAMP_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Bench setup: N_CH=4, SAMPLE_PERIOD=200, PIPE_DEPTH=2. The SPI model has a 17-cycle frame and returns spi_rdata = {8'hA0, cmd[15:8]} of the frame sent 2 earlier.
- Basic sweep: enable=1 → 6 frames (CONVERT 0..3, then 2×16'hE800), then 4 res_valid with res_ch 0,1,2,3 and res_data 16'hA000,16'hA001,16'hA002,16'hA003.
- Config: with enable=0, cfg_req with cfg_cmd=16'h8524 → cfg_ack in the same cycle as the IDLE→ISSUE transition, 3 frames, then cfg_rvalid with cfg_rdata=16'hA085. No res_valid.
- Contention: cfg_req and trigger in the same cycle → the sweep runs first. cfg_ack follows after the sweep's DONE.
- Overrun: SAMPLE_PERIOD=50 with a 6-frame burst of about 108 cycles → overrun=1 and the second trigger is dropped. Sweeps still emit exactly 4 results each.
- Reset mid-sweep: reset during frame 2 → spi_start=0 and overrun=0 immediately. No res_valid afterwards, and the next sweep restarts at ch 0.
